// File: rtl/anim_sequencer.sv
// anim_sequencer
// Frame sequencer for OLED animations. A prescaler divides clk into ticks,
// every HOLD_TICKS ticks the current frame is due to advance, and the step
// follows the playback mode latched at start (LOOP, PINGPONG, ONESHOT, HOLD).
// While the display controller is mid-transfer (disp_busy) a due advance is
// parked in WAIT_DISP, so a refresh never mixes two frames.
//
// Ports:
//   clk           in   1        system clock
//   rst           in   1        asynchronous, active-low reset
//   en            in   1        block enable; low forces IDLE, frame 0
//   start         in   1        one-cycle pulse; (re)starts playback at frame 0
//   mode          in   2        00 LOOP, 01 PINGPONG, 10 ONESHOT, 11 HOLD
//   pause         in   1        level; freezes prescaler and hold counter
//   disp_busy     in   1        display transfer in progress; defers advance
//   frame_idx     out  FRAME_W  current frame index (registered)
//   frame_changed out  1        pulse in the cycle frame_idx takes a new value
//   running       out  1        high in RUN and WAIT_DISP
//   done          out  1        pulse when ONESHOT completes

module anim_sequencer #(
  parameter int NUM_FRAMES = 8,
  parameter int FRAME_W    = 3,
  parameter int TICK_DIV   = 8388608,
  parameter int TICK_W     = 24,
  parameter int HOLD_TICKS = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               start,
  input  logic [1:0]         mode,
  input  logic               pause,
  input  logic               disp_busy,
  output logic [FRAME_W-1:0] frame_idx,
  output logic               frame_changed,
  output logic               running,
  output logic               done
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_RUN       = 2'd1,
    S_WAIT_DISP = 2'd2,
    S_DONE      = 2'd3
  } state_t;

  localparam logic [1:0] MODE_LOOP     = 2'b00;
  localparam logic [1:0] MODE_PINGPONG = 2'b01;
  localparam logic [1:0] MODE_ONESHOT  = 2'b10;
  localparam logic [1:0] MODE_HOLD     = 2'b11;

  localparam int HOLD_W = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;

  localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(NUM_FRAMES - 1);
  localparam logic [FRAME_W-1:0] FRAME_ONE  = FRAME_W'(1);
  localparam logic [FRAME_W-1:0] FRAME_ZERO = {FRAME_W{1'b0}};
  localparam logic [TICK_W-1:0]  TICK_LAST  = TICK_W'(TICK_DIV - 1);
  localparam logic [TICK_W-1:0]  TICK_ONE   = TICK_W'(1);
  localparam logic [TICK_W-1:0]  TICK_ZERO  = {TICK_W{1'b0}};
  localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(HOLD_TICKS - 1);
  localparam logic [HOLD_W-1:0]  HOLD_ONE   = HOLD_W'(1);
  localparam logic [HOLD_W-1:0]  HOLD_ZERO  = {HOLD_W{1'b0}};

  // Registered state
  state_t              state_r;
  logic [FRAME_W-1:0]  frame_r;
  logic                up_r;
  logic [TICK_W-1:0]   presc_r;
  logic [HOLD_W-1:0]   hold_r;
  logic [1:0]          mode_r;
  logic                changed_r;
  logic                running_r;
  logic                done_r;

  // Next-state values
  state_t              state_n;
  logic [FRAME_W-1:0]  frame_n;
  logic                up_n;
  logic [TICK_W-1:0]   presc_n;
  logic [HOLD_W-1:0]   hold_n;
  logic [1:0]          mode_n;
  logic                done_n;

  // Step result for the current frame under the latched mode
  logic [FRAME_W-1:0]  step_frame_s;
  logic                step_up_s;
  logic                step_done_s;

  // Prescaler/hold bookkeeping inside RUN
  logic                tick_s;
  logic                due_s;

  // Compute what the next frame would be if an advance were applied now
  always_comb begin
    step_frame_s = frame_r;
    step_up_s    = up_r;
    step_done_s  = 1'b0;
    case (mode_r)
      MODE_LOOP: begin
        if (frame_r == FRAME_LAST) begin
          step_frame_s = FRAME_ZERO;
        end else begin
          step_frame_s = frame_r + FRAME_ONE;
        end
      end
      MODE_PINGPONG: begin
        // A single-frame animation has no endpoints to bounce between.
        if (NUM_FRAMES == 1) begin
          step_frame_s = frame_r;
        end else if (up_r) begin
          // Turn around at the top without repeating the end frame.
          if (frame_r == FRAME_LAST) begin
            step_up_s    = 1'b0;
            step_frame_s = frame_r - FRAME_ONE;
          end else begin
            step_frame_s = frame_r + FRAME_ONE;
          end
        end else begin
          if (frame_r == FRAME_ZERO) begin
            step_up_s    = 1'b1;
            step_frame_s = frame_r + FRAME_ONE;
          end else begin
            step_frame_s = frame_r - FRAME_ONE;
          end
        end
      end
      MODE_ONESHOT: begin
        if (frame_r == FRAME_LAST) begin
          step_done_s = 1'b1;
        end else begin
          step_frame_s = frame_r + FRAME_ONE;
        end
      end
      default: begin
        step_frame_s = frame_r;
      end
    endcase
  end

  // Next-state logic: enable and start take priority over any due advance
  always_comb begin
    state_n = state_r;
    frame_n = frame_r;
    up_n    = up_r;
    presc_n = presc_r;
    hold_n  = hold_r;
    mode_n  = mode_r;
    done_n  = 1'b0;
    tick_s  = 1'b0;
    due_s   = 1'b0;

    if (!en) begin
      state_n = S_IDLE;
      frame_n = FRAME_ZERO;
      up_n    = 1'b1;
      presc_n = TICK_ZERO;
      hold_n  = HOLD_ZERO;
    end else if (start) begin
      state_n = S_RUN;
      mode_n  = mode;
      frame_n = FRAME_ZERO;
      up_n    = 1'b1;
      presc_n = TICK_ZERO;
      hold_n  = HOLD_ZERO;
    end else begin
      case (state_r)
        S_RUN: begin
          if (!pause) begin
            tick_s = (presc_r == TICK_LAST);
            if (tick_s) begin
              presc_n = TICK_ZERO;
              if (hold_r == HOLD_LAST) begin
                hold_n = HOLD_ZERO;
                due_s  = 1'b1;
              end else begin
                hold_n = hold_r + HOLD_ONE;
              end
            end else begin
              presc_n = presc_r + TICK_ONE;
            end
          end else begin
            presc_n = presc_r;
          end
          // HOLD mode lets the counters run but never advances.
          if (due_s && (mode_r != MODE_HOLD)) begin
            if (disp_busy) begin
              state_n = S_WAIT_DISP;
            end else if (step_done_s) begin
              state_n = S_DONE;
              done_n  = 1'b1;
            end else begin
              frame_n = step_frame_s;
              up_n    = step_up_s;
            end
          end else begin
            state_n = S_RUN;
          end
        end
        S_WAIT_DISP: begin
          // Counters stay frozen; pause does not block the parked step.
          if (!disp_busy) begin
            if (step_done_s) begin
              state_n = S_DONE;
              done_n  = 1'b1;
            end else begin
              state_n = S_RUN;
              frame_n = step_frame_s;
              up_n    = step_up_s;
            end
          end else begin
            state_n = S_WAIT_DISP;
          end
        end
        S_IDLE: begin
          state_n = S_IDLE;
        end
        S_DONE: begin
          state_n = S_DONE;
        end
        default: begin
          state_n = S_IDLE;
        end
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= S_IDLE;
      frame_r   <= FRAME_ZERO;
      up_r      <= 1'b1;
      presc_r   <= TICK_ZERO;
      hold_r    <= HOLD_ZERO;
      mode_r    <= MODE_LOOP;
      changed_r <= 1'b0;
      running_r <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      state_r   <= state_n;
      frame_r   <= frame_n;
      up_r      <= up_n;
      presc_r   <= presc_n;
      hold_r    <= hold_n;
      mode_r    <= mode_n;
      changed_r <= (frame_n != frame_r);
      running_r <= (state_n == S_RUN) || (state_n == S_WAIT_DISP);
      done_r    <= done_n;
    end
  end

  assign frame_idx     = frame_r;
  assign frame_changed = changed_r;
  assign running       = running_r;
  assign done          = done_r;

endmodule

// File: doc/anim_sequencer.md
Name: anim_sequencer

Overview:
Parametrised frame sequencer for OLED animations. It replaces the fixed 2^23 divider and two-step counter with a configurable tick prescaler, per-frame hold, frame count and playback mode. It drives frame_idx into the animation frame memory, which supplies the 132-column row data. Frame changes are deferred while the display controller is mid-transfer, so a refresh never shows two mixed frames.

Parameters:
NUM_FRAMES, 8, number of frames in the animation; legal range 1..256.
FRAME_W, 3, width of frame_idx; must satisfy 2^FRAME_W >= NUM_FRAMES.
TICK_DIV, 8388608, clk cycles per tick; legal range >= 2.
TICK_W, 24, prescaler width; must satisfy 2^TICK_W >= TICK_DIV.
HOLD_TICKS, 1, ticks each frame is shown before it advances; legal range >= 1.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
en  in  1  block enable; while low the block is forced to IDLE
start  in  1  one-cycle pulse; (re)starts playback at frame 0
mode  in  2  playback mode: 00 LOOP, 01 PINGPONG, 10 ONESHOT, 11 HOLD; sampled on start
pause  in  1  level; freezes prescaler and hold counter
disp_busy  in  1  display transfer in progress; frame advance is deferred while high
frame_idx  out  FRAME_W  current frame index (registered)
frame_changed  out  1  one-cycle pulse in the cycle frame_idx takes a new value
running  out  1  high in RUN and WAIT_DISP
done  out  1  one-cycle pulse when ONESHOT completes

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, frame_idx=0, direction=up, prescaler=0, hold counter=0, running=0, frame_changed=0, done=0, latched mode=LOOP.
- States are IDLE, RUN, WAIT_DISP and DONE.
- IDLE/DONE + start (en=1): latch mode, frame_idx=0, direction=up, counters=0, next state RUN. frame_changed pulses only if frame_idx was non-zero.
- RUN:
  - Prescaler increments each cycle when pause=0.
  - At TICK_DIV-1 the prescaler wraps to 0 and emits a tick.
  - Each tick increments the hold counter.
  - When the hold counter would reach HOLD_TICKS, it clears to 0 and an advance is due.
  - First advance occurs TICK_DIV*HOLD_TICKS cycles after RUN entry, assuming no pause.
- Advance due with disp_busy=0: apply the step in that cycle; frame_idx and frame_changed are registered together.
- Advance due with disp_busy=1: go to WAIT_DISP.
  - Prescaler and hold counter are frozen there.
  - Only one advance is ever pending.
  - In the first cycle disp_busy=0, apply the step and return to RUN.
- Step rules:
  - LOOP: N-1 -> 0 wrap.
  - PINGPONG: at N-1 the direction flips to down; at 0 it flips to up. The frame after N-1 is N-2, with no repeated end frame. NUM_FRAMES=1: frame_idx stays 0 and frame_changed never pulses.
  - ONESHOT: advancing from N-1 goes to DONE instead. frame_idx holds N-1, done pulses once, running=0.
  - HOLD: no advances; the frame stays 0 and the state remains RUN.
- start while RUN/WAIT_DISP: restart as from IDLE and drop any pending advance.
- Simultaneous start and due advance: start wins.
- en=0 in any state: next state IDLE, frame_idx=0, counters cleared, running=0, pending advance dropped. start is ignored while en=0.
- pause=1 in WAIT_DISP: the pending step is still applied when disp_busy falls. pause only gates counting.
- mode changes after start have no effect until the next start.
- Reset mid-operation: immediate return to reset values regardless of state.

Test Plan:
All scenarios use NUM_FRAMES=4, TICK_DIV=4, HOLD_TICKS=2, disp_busy=0 unless stated.
- LOOP: start at cycle 0 (RUN entered cycle 1) -> frame_idx 1,2,3,0,1 at cycles 9,17,25,33,41. frame_changed pulses on exactly those cycles. running=1 throughout.
- PINGPONG: start -> frame_idx sequence 0,1,2,3,2,1,0,1, with one change every 8 cycles and no repeated endpoint.
- ONESHOT: start -> 0,1,2,3, then done=1 for one cycle 8 cycles after reaching 3. running=0 and frame_idx=3 afterwards; a second start restarts at 0.
- disp_busy deferral: hold disp_busy=1 across an advance point for 5 cycles -> frame_idx unchanged until the first cycle with disp_busy=0, then +1 with a frame_changed pulse. The next advance comes 8 cycles after that.
- pause/en: pause=1 for 10 cycles mid-frame -> the next change is delayed by exactly 10 cycles. en=0 for 1 cycle -> frame_idx=0, running=0, and start is required to resume.
- Async reset: assert rst=0 between clock edges while at frame 2 in WAIT_DISP -> all outputs reach reset values immediately. After release with no start, frame_idx stays 0.
